// File: rtl/sce_pcr_seq.sv
// ---------------------------------------------------------------------------
// sce_pcr_seq
// Power/clock/reset sequencer for the SCE datapath. Runs a four-phase
// power request/acknowledge handshake with the top-level power manager,
// enables the per-channel gated clocks, releases the per-channel resets
// one enabled channel at a time, and generates per-channel soft reset
// pulses while the block is powered.
//
// Ports
//   i_clk        : single clock
//   i_rst        : asynchronous active-high reset
//   i_pwr_req    : power request level (1 = up, 0 = down)
//   o_pwr_ack    : handshake acknowledge
//   i_ch_en      : channel enable mask, latched when leaving OFF
//   i_srst_req   : per-channel soft reset request, honoured in ON only
//   o_ch_cgen    : per-channel clock-gate enable
//   o_ch_rstn    : per-channel reset, active-low
//   o_busy       : sequencing in progress (CLK_ON, RELEASE, CLK_OFF)
//   o_state      : OFF=0, CLK_ON=1, RELEASE=2, ON=3, CLK_OFF=4
// ---------------------------------------------------------------------------
module sce_pcr_seq #(
    parameter int N_CH       = 4,
    parameter int CLK_SETTLE = 4,
    parameter int STAGGER    = 2,
    parameter int SRST_CYC   = 3
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_pwr_req,
    output logic            o_pwr_ack,
    input  logic [N_CH-1:0] i_ch_en,
    input  logic [N_CH-1:0] i_srst_req,
    output logic [N_CH-1:0] o_ch_cgen,
    output logic [N_CH-1:0] o_ch_rstn,
    output logic            o_busy,
    output logic [2:0]      o_state
);

    localparam int CNT_MAX_A = (CLK_SETTLE > STAGGER) ? CLK_SETTLE : STAGGER;
    localparam int CNT_MAX   = (CNT_MAX_A > SRST_CYC) ? CNT_MAX_A : SRST_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1);

    // Phase counters are loaded with (length - 1) because the loading edge
    // itself is the first edge of the phase; soft-reset timers are loaded
    // with the full length and release the channel as they reach zero.
    localparam logic [CW-1:0] SETTLE_LD  = CW'(CLK_SETTLE - 1);
    localparam logic [CW-1:0] STAGGER_LD = CW'(STAGGER - 1);
    localparam logic [CW-1:0] SRST_LD    = CW'(SRST_CYC);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_CLK_ON  = 3'd1,
        ST_RELEASE = 3'd2,
        ST_ON      = 3'd3,
        ST_CLK_OFF = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [N_CH-1:0] r_mask;
    logic [N_CH-1:0] r_cgen;
    logic [N_CH-1:0] r_rstn;
    logic            r_ack;
    logic            r_busy;
    logic [CW-1:0]   r_timer [N_CH];

    state_t          w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [N_CH-1:0] w_mask_nxt;
    logic [N_CH-1:0] w_cgen_nxt;
    logic [N_CH-1:0] w_rstn_nxt;
    logic            w_ack_nxt;
    logic            w_busy_nxt;
    logic [CW-1:0]   w_timer_nxt [N_CH];

    // Enabled channels still held in reset; during power-up nothing else
    // drives CH_RSTN, so these are exactly the channels left to release.
    logic [N_CH-1:0] w_pending;
    logic [N_CH-1:0] w_first;

    assign w_pending = r_mask & ~r_rstn;
    // Two's-complement trick isolates the lowest set bit: the next channel
    // in ascending order, skipping disabled channels in zero cycles.
    assign w_first   = w_pending & (~w_pending + N_CH'(1));

    always_comb begin
        // NOTE: every combinational output gets a default before the case
        // statement so no path leaves a signal unassigned (no latches).
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mask_nxt  = r_mask;
        w_cgen_nxt  = r_cgen;
        w_rstn_nxt  = r_rstn;
        w_ack_nxt   = r_ack;
        for (int i = 0; i < N_CH; i++) begin
            w_timer_nxt[i] = r_timer[i];
        end

        case (r_state)
            ST_OFF: begin
                if (i_pwr_req) begin
                    w_mask_nxt  = i_ch_en;
                    w_cgen_nxt  = i_ch_en;
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = ST_CLK_ON;
                end
            end

            // CLK_ON and RELEASE share the tail: when the counter expires,
            // either release the next pending channel or, with none left,
            // complete the handshake. An all-zero mask therefore goes
            // straight from CLK_ON to ON.
            ST_CLK_ON, ST_RELEASE: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (w_pending == '0) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_ON;
                end else begin
                    w_rstn_nxt  = r_rstn | w_first;
                    w_cnt_nxt   = STAGGER_LD;
                    w_state_nxt = ST_RELEASE;
                end
            end

            ST_ON: begin
                if (!i_pwr_req) begin
                    // Power-down wins over any soft request on this edge.
                    w_rstn_nxt  = '0;
                    w_cnt_nxt   = SETTLE_LD;
                    w_state_nxt = ST_CLK_OFF;
                    for (int i = 0; i < N_CH; i++) begin
                        w_timer_nxt[i] = '0;
                    end
                end else begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (r_mask[i] && i_srst_req[i]) begin
                            // A repeat request simply reloads the timer.
                            w_rstn_nxt[i]  = 1'b0;
                            w_timer_nxt[i] = SRST_LD;
                        end else if (r_timer[i] != '0) begin
                            w_timer_nxt[i] = r_timer[i] - CNT_ONE;
                            if (r_timer[i] == CNT_ONE) begin
                                w_rstn_nxt[i] = 1'b1;
                            end
                        end
                    end
                end
            end

            ST_CLK_OFF: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else begin
                    w_cgen_nxt  = '0;
                    w_ack_nxt   = 1'b0;
                    w_state_nxt = ST_OFF;
                end
            end

            default: begin
                w_state_nxt = ST_OFF;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_CLK_ON)  ||
                     (w_state_nxt == ST_RELEASE) ||
                     (w_state_nxt == ST_CLK_OFF);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_mask  <= '0;
            r_cgen  <= '0;
            r_rstn  <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            // NOTE: the timer array is reset element by element; it is a
            // handful of flops, and a stale timer after reset would release
            // a channel that should be held.
            for (int i = 0; i < N_CH; i++) begin
                r_timer[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
            r_cgen  <= w_cgen_nxt;
            r_rstn  <= w_rstn_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= w_busy_nxt;
            for (int i = 0; i < N_CH; i++) begin
                r_timer[i] <= w_timer_nxt[i];
            end
        end
    end

    assign o_state   = r_state;
    assign o_pwr_ack = r_ack;
    assign o_ch_cgen = r_cgen;
    assign o_ch_rstn = r_rstn;
    assign o_busy    = r_busy;

endmodule
